// File: rtl/pc_ir_unit_pkg.sv
// Shared datapath definitions: instruction field map, opcodes and next-PC selects.
// Holds the helpers the fetch stage and the decoder both rely on.
package cpu_defs;

  localparam int INSTR_W = 19;

  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 14;
  localparam int RD_MSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int JMP_MSB = 13;
  localparam int JMP_LSB = 0;
  localparam int JMP_W   = 14;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_ADDI = 5'd3;
  localparam logic [4:0] OP_LW   = 5'd4;
  localparam logic [4:0] OP_SW   = 5'd5;
  localparam logic [4:0] OP_BEQ  = 5'd6;
  localparam logic [4:0] OP_J    = 5'd7;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pc_src_e;

  function automatic logic [15:0] sext_imm6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of the instruction register into its fields.
module instr_field_decode
  import cpu_defs::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [4:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm_sext,
  output logic [JMP_W-1:0]   jump_addr
);

  assign opcode    = ir[OP_MSB:OP_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign rt        = ir[RT_MSB:RT_LSB];
  assign imm_sext  = sext_imm6(ir[IMM_MSB:IMM_LSB]);
  assign jump_addr = ir[JMP_MSB:JMP_LSB];

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR stage of the multicycle datapath: fetch handshake, IR latch,
// ALUOut register and next-PC selection.
module pc_ir_unit
  import cpu_defs::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               IRWrite,
  input  logic               PCWrite,
  input  logic               PCWriteCond,
  input  logic [1:0]         PCSource,
  input  logic               alu_zero,
  input  logic [PC_W-1:0]    alu_result,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    pc,
  output logic [4:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm_sext,
  output logic [13:0]        jump_addr,
  output logic [PC_W-1:0]    alu_out,
  output logic               instr_valid,
  output logic               stall
);

  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    alu_out_r;
  logic [INSTR_W-1:0] ir_r;
  logic               pending_r;
  logic               instr_valid_r;
  logic               imem_req_s;
  logic               stall_s;
  logic               fetch_done_s;
  logic               pc_en_s;
  logic [PC_W-1:0]    pc_next_s;
  logic [13:0]        jump_addr_s;

  // A fetch stays outstanding from IRWrite until memory answers.
  assign imem_req_s   = IRWrite | pending_r;
  assign stall_s      = imem_req_s & ~imem_valid;
  assign fetch_done_s = imem_req_s & imem_valid;
  assign pc_en_s      = (PCWrite | (PCWriteCond & alu_zero)) & ~stall_s;

  // Next-PC mux; the reserved select keeps the current PC.
  always_comb begin
    pc_next_s = pc_r;
    case (PCSource)
      PCSRC_ALU:    pc_next_s = alu_result;
      PCSRC_ALUOUT: pc_next_s = alu_out_r;
      PCSRC_JUMP:   pc_next_s[JMP_W-1:0] = jump_addr_s;
      default:      pc_next_s = pc_r;
    endcase
  end

  // Architectural state: PC, IR, ALUOut and the fetch-outstanding flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= '0;
      alu_out_r     <= '0;
      ir_r          <= '0;
      pending_r     <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      if (pc_en_s) begin
        pc_r <= pc_next_s;
      end
      if (imem_valid) begin
        pending_r <= 1'b0;
      end else if (imem_req_s) begin
        pending_r <= 1'b1;
      end
      if (fetch_done_s) begin
        ir_r          <= imem_rdata;
        instr_valid_r <= 1'b1;
      end
      if (!stall_s) begin
        alu_out_r <= alu_result;
      end
    end
  end

  instr_field_decode u_decode (
    .ir        (ir_r),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .imm_sext  (imm_sext),
    .jump_addr (jump_addr_s)
  );

  assign jump_addr   = jump_addr_s;
  assign pc          = pc_r;
  assign imem_addr   = pc_r;
  assign alu_out     = alu_out_r;
  assign instr_valid = instr_valid_r;
  assign imem_req    = imem_req_s;
  assign stall       = stall_s;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRWrite, PCWrite, PCWriteCond, alu_zero, imem_valid;
  logic [1:0]  PCSource;
  logic [15:0] alu_result;
  logic [18:0] imem_rdata;
  logic [15:0] imem_addr, pc, alu_out, imm_sext;
  logic        imem_req, instr_valid, stall;
  logic [4:0]  opcode;
  logic [3:0]  rd, rs, rt;
  logic [13:0] jump_addr;

  always #5 clk = ~clk;

  pc_ir_unit dut (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .alu_zero(alu_zero),
    .alu_result(alu_result), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .imem_addr(imem_addr), .imem_req(imem_req), .pc(pc), .opcode(opcode),
    .rd(rd), .rs(rs), .rt(rt), .imm_sext(imm_sext), .jump_addr(jump_addr),
    .alu_out(alu_out), .instr_valid(instr_valid), .stall(stall)
  );

  typedef struct {
    int pc;
    int ir;
    int aluo;
    int iv;
    int stl;
    int req;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference state, kept as plain integers
  int m_pc, m_ir, m_aluo, m_iv, m_pend;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_aluo = 0; m_iv = 0; m_pend = 0;
  endtask

  // one clock of stimulus; the reference advances by the fetch/PC rules
  task automatic drive(input int irw, input int pcw, input int pcwc, input int src,
                       input int z, input int ar, input int rdat, input int v);
    exp_t e;
    int req, stl, pcen, npc;
    IRWrite     = irw[0];
    PCWrite     = pcw[0];
    PCWriteCond = pcwc[0];
    PCSource    = src[1:0];
    alu_zero    = z[0];
    alu_result  = ar[15:0];
    imem_rdata  = rdat[18:0];
    imem_valid  = v[0];
    req = (irw != 0 || m_pend != 0) ? 1 : 0;
    stl = (req != 0 && v == 0) ? 1 : 0;
    e.pc = m_pc; e.ir = m_ir; e.aluo = m_aluo; e.iv = m_iv; e.stl = stl; e.req = req;
    q.push_back(e);
    if (reset) begin
      model_reset();
    end else begin
      pcen = ((pcw != 0 || (pcwc != 0 && z != 0)) && stl == 0) ? 1 : 0;
      npc = m_pc;
      if (pcen != 0) begin
        if (src == 0) npc = ar & 65535;
        else if (src == 1) npc = m_aluo;
        else if (src == 2) npc = (m_pc & 32'hC000) | (m_ir & 32'h3FFF);
      end
      if (stl == 0) m_aluo = ar & 65535;
      if (req != 0 && v != 0) begin
        m_ir = rdat & 32'h7FFFF;
        m_iv = 1;
      end
      if (v != 0) m_pend = 0;
      else if (req != 0) m_pend = 1;
      m_pc = npc;
    end
    @(posedge clk);
    #2;
  endtask

  // reset asserted mid-cycle while a fetch may be outstanding
  task automatic reset_mid();
    exp_t e;
    IRWrite = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; imem_valid = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    e.pc = 0; e.ir = 0; e.aluo = 0; e.iv = 0; e.stl = 0; e.req = 0;
    q.push_back(e);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // monitor: compare every observable output against the popped expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      int imm;
      e = q.pop_front();
      imm = e.ir & 63;
      if (imm >= 32) imm = imm - 64;
      check("pc",          int'(pc),          e.pc);
      check("imem_addr",   int'(imem_addr),   e.pc);
      check("alu_out",     int'(alu_out),     e.aluo);
      check("instr_valid", int'(instr_valid), e.iv);
      check("stall",       int'(stall),       e.stl);
      check("imem_req",    int'(imem_req),    e.req);
      check("opcode",      int'(opcode),      (e.ir >> 14) & 31);
      check("rd",          int'(rd),          (e.ir >> 10) & 15);
      check("rs",          int'(rs),          (e.ir >> 6) & 15);
      check("rt",          int'(rt),          (e.ir >> 2) & 15);
      check("jump_addr",   int'(jump_addr),   e.ir & 32'h3FFF);
      check("imm_sext",    int'(imm_sext),    imm & 65535);
    end
  end

  initial begin
    reset = 1'b1;
    IRWrite = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = 2'b00;
    alu_zero = 1'b0; alu_result = 16'h0000; imem_rdata = 19'h00000; imem_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;

    // first fetch
    drive(1, 0, 0, 0, 0, 16'h0005, 19'h07600, 1);
    // fetch with PC update held off by three stall cycles
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 16'h0001, 19'h12345, 0);
    drive(1, 1, 0, 0, 0, 16'h0001, 19'h2ABCD, 1);
    // conditional branch through ALUOut
    drive(0, 0, 0, 0, 0, 16'h0020, 0, 0);
    drive(0, 0, 1, 1, 0, 16'h0020, 0, 0);
    drive(0, 0, 1, 1, 1, 16'h0020, 0, 0);
    // jump keeps the upper PC bits
    drive(0, 1, 0, 0, 0, 16'hC005, 0, 0);
    drive(1, 0, 0, 0, 0, 16'h1111, {5'd7, 14'h0123}, 1);
    drive(0, 1, 0, 2, 0, 16'h2222, 0, 0);
    drive(0, 1, 0, 3, 1, 16'h3333, 0, 0);
    drive(0, 1, 1, 3, 1, 16'h4444, 0, 0);
    // immediate sign extension, negative then positive
    drive(1, 0, 0, 0, 0, 16'h0000, 19'h00021, 1);
    drive(1, 0, 0, 0, 0, 16'h0000, 19'h0001F, 1);
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    // stray valid without request is ignored
    drive(0, 0, 0, 0, 0, 16'h0007, 19'h7FFFF, 1);
    // reset while a fetch is outstanding, then a late valid
    drive(1, 0, 0, 0, 0, 16'h0009, 0, 0);
    reset_mid();
    drive(0, 0, 0, 0, 0, 16'h000A, 19'h5A5A5, 1);
    drive(0, 0, 0, 0, 0, 16'h000B, 0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
      end else begin
        drive(($urandom_range(0, 2) == 0) ? 1 : 0,
              ($urandom_range(0, 2) == 0) ? 1 : 0,
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)),
              int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 19'h7FFFF)),
              ($urandom_range(0, 2) != 0) ? 1 : 0);
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
